bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter using the shift-add-3 (double-dabble) method, one bit per clock. It sits between the latched random number (15-bit LFSR sample) and the per-digit seven-segment decoders, so the board shows the value in decimal instead of hex. It uses a start/busy/done handshake and holds its last result on the outputs until the next conversion completes.

---
 rtl/bin2bcd_seq.sv | 118 +++++++++++
 tb/tb_bin2bcd_seq.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-add-3), one input bit per clock.
// Start/busy/done handshake; the last result is held until the next conversion completes.
module bin2bcd_seq #(
  parameter int IN_W   = 15,
  parameter int DIGITS = 5,
  parameter int CNT_W  = 4
) (
  input  logic                  ADC_CLK_10,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin_in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd_out,
  output logic                  overflow,
  output logic [1:0]            dbg_state
);

  // Handshake: start is accepted only in IDLE; busy is high for the IN_W shift
  // cycles; done pulses for one cycle, in the same cycle bcd_out/overflow update.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [IN_W-1:0]       bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic                  acc_q, acc_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*DIGITS-1:0]   bcd_out_q, bcd_out_d;
  logic                  overflow_q, overflow_d;
  logic                  done_q, done_d;

  logic [4*DIGITS-1:0]   adj;
  logic [4*DIGITS:0]     shifted;

  // Per-digit add-3 correction; digits never carry into each other.
  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

  // Top bit is what falls out of the most significant digit.
  assign shifted = {adj, bin_q[IN_W-1]};

  always_comb begin
    state_d    = state_q;
    bin_d      = bin_q;
    bcd_d      = bcd_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_out_d  = bcd_out_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          bin_d   = bin_in;
          bcd_d   = '0;
          acc_d   = 1'b0;
          cnt_d   = CNT_W'(IN_W);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        bcd_d = shifted[4*DIGITS-1:0];
        acc_d = acc_q | shifted[4*DIGITS];
        bin_d = {bin_q[IN_W-2:0], 1'b0};
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = FIN;
        end
      end
      FIN: begin
        bcd_out_d  = bcd_q;
        overflow_d = acc_q;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge ADC_CLK_10 or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bin_q      <= '0;
      bcd_q      <= '0;
      acc_q      <= 1'b0;
      cnt_q      <= '0;
      bcd_out_q  <= '0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      bin_q      <= bin_d;
      bcd_q      <= bcd_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bcd_out_q  <= bcd_out_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy      = (state_q == SHIFT);
  assign done      = done_q;
  assign bcd_out   = bcd_out_q;
  assign overflow  = overflow_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: directed and random conversions on the default build and
// on an 8-bit/2-digit build, checked against an integer-arithmetic decimal model.
module tb_bin2bcd_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [14:0] bin_in;
  logic        busy, done, overflow;
  logic [19:0] bcd_out;
  logic [1:0]  dbg_state;

  logic        s_start;
  logic [7:0]  s_bin;
  logic        s_busy, s_done, s_overflow;
  logic [7:0]  s_bcd_out;
  logic [1:0]  s_dbg_state;

  int checks = 0;
  int errors = 0;

  logic [20:0] exp_q[$];
  logic [20:0] s_exp_q[$];

  bin2bcd_seq u_dut (
    .ADC_CLK_10(clk), .rst_n(rst_n), .start(start), .bin_in(bin_in),
    .busy(busy), .done(done), .bcd_out(bcd_out), .overflow(overflow),
    .dbg_state(dbg_state)
  );

  bin2bcd_seq #(.IN_W(8), .DIGITS(2), .CNT_W(4)) u_small (
    .ADC_CLK_10(clk), .rst_n(rst_n), .start(s_start), .bin_in(s_bin),
    .busy(s_busy), .done(s_done), .bcd_out(s_bcd_out), .overflow(s_overflow),
    .dbg_state(s_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: decimal digits of v modulo 10^digits, overflow when v does not fit.
  function automatic logic [20:0] exp_of(input int v, input int digits);
    int r, lim;
    logic [20:0] e;
    lim = 1;
    for (int i = 0; i < digits; i++) lim = lim * 10;
    e = '0;
    e[20] = (v >= lim);
    r = v % lim;
    for (int k = 0; k < digits; k++) begin
      e[4*k +: 4] = 4'(r % 10);
      r = r / 10;
    end
    return e;
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    if (rst_n) begin
      if (busy && done) check("busy_done_overlap", 32'(busy & done), 32'd0);
      if (done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [20:0] e;
          e = exp_q.pop_front();
          check("bcd_out", 32'(bcd_out), 32'(e[19:0]));
          check("overflow", 32'(overflow), 32'(e[20]));
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (s_busy && s_done) check("s_busy_done_overlap", 32'(s_busy & s_done), 32'd0);
      if (s_done) begin
        if (s_exp_q.size() == 0) begin
          check("s_unexpected_done", 32'd1, 32'd0);
        end else begin
          logic [20:0] e;
          e = s_exp_q.pop_front();
          check("s_bcd_out", 32'(s_bcd_out), 32'(e[7:0]));
          check("s_overflow", 32'(s_overflow), 32'(e[20]));
        end
      end
    end
  end

  // driver tasks
  task automatic convert(input int v, input bit check_timing);
    int n, busy_cnt;
    bit seen;
    @(negedge clk);
    start  = 1'b1;
    bin_in = 15'(v);
    exp_q.push_back(exp_of(v, 5));
    @(posedge clk);
    busy_cnt = 0;
    seen = 1'b0;
    for (n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (busy) busy_cnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("done_seen", 32'(seen), 32'd1);
    if (check_timing && seen) begin
      check("latency", 32'(n), 32'd16);
      check("busy_cycles", 32'(busy_cnt), 32'd15);
      @(negedge clk);
      check("done_width", 32'(done), 32'd0);
    end
  endtask

  task automatic convert_small(input int v);
    int n;
    bit seen;
    @(negedge clk);
    s_start = 1'b1;
    s_bin   = 8'(v);
    s_exp_q.push_back(exp_of(v, 2));
    @(posedge clk);
    seen = 1'b0;
    for (n = 0; n < 30; n++) begin
      @(negedge clk);
      if (n == 0) s_start = 1'b0;
      if (s_done) begin
        seen = 1'b1;
        break;
      end
    end
    check("s_done_seen", 32'(seen), 32'd1);
    if (seen) check("s_latency", 32'(n), 32'd9);
  endtask

  initial begin
    int d_at[3];
    int nd, dones;
    logic [19:0] last_val;

    start = 1'b0; bin_in = '0; s_start = 1'b0; s_bin = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd_out), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    convert(0, 1'b1);
    convert(32767, 1'b1);

    // start while busy is ignored
    @(negedge clk);
    start = 1'b1; bin_in = 15'd9999;
    exp_q.push_back(exp_of(9999, 5));
    @(posedge clk);
    nd = -1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
      if (n == 5) begin start = 1'b1; bin_in = 15'd1; end
      if (n == 6) start = 1'b0;
      if (done) begin nd = n; break; end
    end
    check("ignored_start_latency", 32'(nd), 32'd16);
    repeat (3) @(negedge clk);
    check("no_extra_done", 32'(exp_q.size()), 32'd0);
    convert(1, 1'b1);

    // start held high: back-to-back conversions
    @(negedge clk);
    start = 1'b1; bin_in = 15'd100;
    exp_q.push_back(exp_of(100, 5));
    @(posedge clk);
    dones = 0;
    last_val = '0;
    for (int n = 0; n < 56; n++) begin
      @(negedge clk);
      if (n == 0) begin bin_in = 15'd4095; exp_q.push_back(exp_of(4095, 5)); end
      if (n == 17) begin bin_in = 15'd12345; exp_q.push_back(exp_of(12345, 5)); end
      if (n == 34) start = 1'b0;
      if (done) begin
        if (dones < 3) d_at[dones] = n;
        dones++;
        last_val = bcd_out;
      end else if (dones > 0) begin
        check("bcd_hold", 32'(bcd_out), 32'(last_val));
      end
    end
    check("held_done_count", 32'(dones), 32'd3);
    if (dones == 3) begin
      check("held_done0", 32'(d_at[0]), 32'd16);
      check("held_gap1", 32'(d_at[1] - d_at[0]), 32'd17);
      check("held_gap2", 32'(d_at[2] - d_at[1]), 32'd17);
    end

    // reset in the middle of a conversion
    @(negedge clk);
    start = 1'b1; bin_in = 15'd32767;
    @(posedge clk);
    for (int n = 0; n < 7; n++) begin
      @(negedge clk);
      if (n == 0) start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_bcd", 32'(bcd_out), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'd0);

    // random conversions
    for (int i = 0; i < 12; i++) begin
      convert(int'($urandom_range(0, 32767)), 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // narrow build with overflow
    convert_small(99);
    convert_small(100);
    convert_small(255);
    for (int i = 0; i < 10; i++) convert_small(int'($urandom_range(0, 255)));

    repeat (3) @(negedge clk);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    check("s_exp_q_empty", 32'(s_exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
